// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges Decode load/store requests onto a req/gnt/rvalid data-memory port.
//   One transaction is in flight at a time. Sub-word stores are lane-replicated,
//   and loads are lane-selected and sign/zero-extended. A watchdog aborts any
//   transaction that stays in REQ or WAIT too long.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   en_lsu_ip             load/store request from Decode
//   lsu_operator_ip[2:0]  LW=0 LH=1 LB=2 LHU=3 LBU=4 SW=5 SH=6 SB=7
//   addr_ip, addr_valid_ip  effective address and its valid flag
//   wdata_ip              store data
//   mem_data_op           extended load data (holds until the next load completes)
//   mem_data_valid_op     1-cycle pulse when a load completes
//   store_done_op         1-cycle pulse when a store completes
//   misaligned_op         1-cycle pulse when a request is rejected for alignment
//   timeout_op            1-cycle pulse when the watchdog aborts a transaction
//   lsu_busy_op           high whenever the FSM is not IDLE
//   data_*                memory port (word address, byte enables, lane data)
//   lsu_state_op          current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Handshake: a request is issued by holding data_req_op high with address,
// we, be and wdata stable. The transfer is accepted on the cycle in which
// data_req_op and data_gnt_ip are both high. The response is the first
// data_rvalid_ip seen in a later cycle; an rvalid in the grant cycle or while
// IDLE is ignored. Every output is driven from a register.

`timescale 1ns/1ps

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_lsu_ip,
  input  logic [2:0]  lsu_operator_ip,
  input  logic [31:0] addr_ip,
  input  logic        addr_valid_ip,
  input  logic [31:0] wdata_ip,
  output logic [31:0] mem_data_op,
  output logic        mem_data_valid_op,
  output logic        store_done_op,
  output logic        misaligned_op,
  output logic        timeout_op,
  output logic        lsu_busy_op,
  output logic        data_req_op,
  input  logic        data_gnt_ip,
  output logic [31:0] data_addr_op,
  output logic        data_we_op,
  output logic [3:0]  data_be_op,
  output logic [31:0] data_wdata_op,
  input  logic        data_rvalid_ip,
  input  logic [31:0] data_rdata_ip,
  output logic [1:0]  lsu_state_op
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // Watchdog value of the last permitted cycle in REQ/WAIT.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_wdog;

  // Latched transaction attributes
  logic [2:0]  r_op;
  logic [1:0]  r_off;

  // Output registers
  logic [31:0] r_mem_data;
  logic        r_mem_valid;
  logic        r_store_done;
  logic        r_misaligned;
  logic        r_timeout;
  logic        r_busy;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  // Request decode
  logic        w_in_store;
  logic        w_in_misaligned;
  logic [3:0]  w_in_be;
  logic [31:0] w_in_wdata;

  // Events
  logic        w_new_req;
  logic        w_start;
  logic        w_reject;
  logic        w_gnt_evt;
  logic        w_done;
  logic        w_timeout;

  // Next values of the registered outputs
  logic        w_req_nxt;
  logic        w_busy_nxt;
  logic        w_valid_nxt;
  logic        w_store_done_nxt;
  logic        w_mis_nxt;
  logic        w_to_nxt;

  // Load extraction
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Incoming request decode: byte enables, store lane data, alignment.
  always_comb begin
    w_in_be         = 4'b0001 << addr_ip[1:0];
    w_in_misaligned = 1'b0;
    w_in_wdata      = wdata_ip;
    w_in_store      = (lsu_operator_ip == OP_SW) || (lsu_operator_ip == OP_SH) ||
                      (lsu_operator_ip == OP_SB);
    case (lsu_operator_ip)
      OP_LW, OP_SW: begin
        w_in_be         = 4'b1111;
        w_in_misaligned = (addr_ip[1:0] != 2'b00);
      end
      OP_LH, OP_LHU, OP_SH: begin
        w_in_be         = addr_ip[1] ? 4'b1100 : 4'b0011;
        w_in_misaligned = addr_ip[0];
      end
      default: ;
    endcase
    case (lsu_operator_ip)
      OP_SH:   w_in_wdata = {2{wdata_ip[15:0]}};
      OP_SB:   w_in_wdata = {4{wdata_ip[7:0]}};
      default: w_in_wdata = wdata_ip;
    endcase
  end

  assign w_new_req = (r_state == S_IDLE) && en_lsu_ip && addr_valid_ip;
  assign w_start   = w_new_req && !w_in_misaligned;
  assign w_reject  = w_new_req && w_in_misaligned;
  assign w_gnt_evt = (r_state == S_REQ) && data_gnt_ip;
  // Only WAIT listens to rvalid, so an rvalid in the grant cycle is dropped.
  assign w_done    = (r_state == S_WAIT) && data_rvalid_ip;
  // A grant or response in the final cycle wins over the abort.
  assign w_timeout = (((r_state == S_REQ) && !data_gnt_ip) ||
                      ((r_state == S_WAIT) && !data_rvalid_ip)) &&
                     (r_wdog == WDOG_LAST);

  // State register and watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start || w_gnt_evt) begin
        r_wdog <= '0;
      end else if (r_state != S_IDLE) begin
        r_wdog <= r_wdog + 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_REQ;
      S_REQ: begin
        if (data_gnt_ip)    w_state_nxt = S_WAIT;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (data_rvalid_ip) w_state_nxt = S_IDLE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the output registers
  always_comb begin
    w_req_nxt        = (w_state_nxt == S_REQ);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_valid_nxt      = w_done && !r_we;
    w_store_done_nxt = w_done && r_we;
    w_mis_nxt        = w_reject;
    w_to_nxt         = w_timeout;
  end

  // Pick the addressed lane from the returned word and extend it.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = data_rdata_ip[7:0];
      2'd1:    w_byte = data_rdata_ip[15:8];
      2'd2:    w_byte = data_rdata_ip[23:16];
      default: w_byte = data_rdata_ip[31:24];
    endcase
    w_half = r_off[1] ? data_rdata_ip[31:16] : data_rdata_ip[15:0];
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = data_rdata_ip;
    endcase
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op         <= '0;
      r_off        <= '0;
      r_mem_data   <= '0;
      r_mem_valid  <= 1'b0;
      r_store_done <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
    end else begin
      r_mem_valid  <= w_valid_nxt;
      r_store_done <= w_store_done_nxt;
      r_misaligned <= w_mis_nxt;
      r_timeout    <= w_to_nxt;
      r_busy       <= w_busy_nxt;
      r_req        <= w_req_nxt;
      // Memory-port fields only change on acceptance, so they stay stable in REQ.
      if (w_start) begin
        r_op    <= lsu_operator_ip;
        r_off   <= addr_ip[1:0];
        r_addr  <= {addr_ip[31:2], 2'b00};
        r_we    <= w_in_store;
        r_be    <= w_in_be;
        r_wdata <= w_in_wdata;
      end
      if (w_valid_nxt) begin
        r_mem_data <= w_load_data;
      end
    end
  end

  assign mem_data_op       = r_mem_data;
  assign mem_data_valid_op = r_mem_valid;
  assign store_done_op     = r_store_done;
  assign misaligned_op     = r_misaligned;
  assign timeout_op        = r_timeout;
  assign lsu_busy_op       = r_busy;
  assign data_req_op       = r_req;
  assign data_addr_op      = r_addr;
  assign data_we_op        = r_we;
  assign data_be_op        = r_be;
  assign data_wdata_op     = r_wdata;
  assign lsu_state_op      = r_state;

endmodule
